// File: rtl/game_controller.sv
// game_controller: two-player timed door-pick round FSM with lives, reveal and game-over detection
module game_controller #(
    parameter int TICKS_PER_SEC = 25_000_000,
    parameter int ROUND_SECS    = 10,
    parameter int REVEAL_SECS   = 2,
    parameter int START_LIVES   = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       p1_valid,
    input  logic [1:0] p1_door,
    input  logic       p2_valid,
    input  logic [1:0] p2_door,
    output logic [1:0] p1_lives,
    output logic [1:0] p2_lives,
    output logic [1:0] correct_door,
    output logic       time_up,
    output logic [3:0] secs_left,
    output logic       game_over,
    output logic [1:0] winner
);
    localparam int CW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    typedef enum logic [1:0] {IDLE, ROUND, REVEAL, OVER} state_t;
    state_t        state_q, state_d;
    logic [7:0]    lfsr_q, lfsr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          tick;
    logic [1:0]    hidden_q, hidden_d, c1_q, c1_d, c2_q, c2_d;
    logic [1:0]    p1_lives_q, p1_lives_d, p2_lives_q, p2_lives_d;
    logic [1:0]    correct_q, correct_d, winner_q, winner_d;
    logic [3:0]    secs_q, secs_d, rev_q, rev_d;
    logic          time_up_q, time_up_d, game_over_q, game_over_d;
    logic          entering;

    assign p1_lives     = p1_lives_q;
    assign p2_lives     = p2_lives_q;
    assign correct_door = correct_q;
    assign time_up      = time_up_q;
    assign secs_left    = secs_q;
    assign game_over    = game_over_q;
    assign winner       = winner_q;

    // Next-state logic: transitions first, then the one-shot actions of whichever state is entered
    always_comb begin
        lfsr_d      = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        tick        = cnt_q == CW'(TICKS_PER_SEC - 1);
        state_d     = state_q;
        hidden_d    = hidden_q;
        c1_d        = c1_q;
        c2_d        = c2_q;
        p1_lives_d  = p1_lives_q;
        p2_lives_d  = p2_lives_q;
        correct_d   = correct_q;
        winner_d    = winner_q;
        secs_d      = secs_q;
        rev_d       = rev_q;
        time_up_d   = time_up_q;
        game_over_d = game_over_q;
        case (state_q)
            IDLE, OVER: if (start) state_d = ROUND;
            ROUND: begin
                if (c1_q != 2'd0 && c2_q != 2'd0) begin
                    state_d = REVEAL;
                end else if (tick && secs_q == 4'd1) begin
                    state_d = REVEAL;
                    secs_d  = 4'd0;
                end else begin
                    if (tick) secs_d = secs_q - 4'd1;
                    if (c1_q == 2'd0 && p1_valid && p1_door != 2'd0) c1_d = p1_door;
                    if (c2_q == 2'd0 && p2_valid && p2_door != 2'd0) c2_d = p2_door;
                end
            end
            REVEAL: if (tick) begin
                rev_d = rev_q - 4'd1;
                if (rev_q == 4'd1) state_d = (p1_lives_q == 2'd0 || p2_lives_q == 2'd0) ? OVER : ROUND;
            end
            default: ;
        endcase
        entering = state_d != state_q;
        cnt_d    = (entering || tick) ? '0 : cnt_q + CW'(1);
        if (entering && state_d == ROUND) begin
            secs_d    = 4'(ROUND_SECS);
            correct_d = 2'd0;
            time_up_d = 1'b0;
            c1_d      = 2'd0;
            c2_d      = 2'd0;
            hidden_d  = (lfsr_q[1:0] == 2'd0) ? 2'd1 : lfsr_q[1:0];
            if (state_q != REVEAL) begin
                p1_lives_d  = 2'(START_LIVES);
                p2_lives_d  = 2'(START_LIVES);
                winner_d    = 2'b00;
                game_over_d = 1'b0;
            end
        end
        if (entering && state_d == REVEAL) begin
            correct_d  = hidden_q;
            time_up_d  = 1'b1;
            rev_d      = 4'(REVEAL_SECS);
            p1_lives_d = (c1_q != hidden_q && p1_lives_q != 2'd0) ? p1_lives_q - 2'd1 : p1_lives_q;
            p2_lives_d = (c2_q != hidden_q && p2_lives_q != 2'd0) ? p2_lives_q - 2'd1 : p2_lives_q;
        end
        if (entering && state_d == OVER) begin
            game_over_d = 1'b1;
            winner_d    = {p1_lives_q == 2'd0, p2_lives_q == 2'd0};
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            lfsr_q      <= 8'h01;
            cnt_q       <= '0;
            hidden_q    <= 2'd0;
            c1_q        <= 2'd0;
            c2_q        <= 2'd0;
            p1_lives_q  <= 2'(START_LIVES);
            p2_lives_q  <= 2'(START_LIVES);
            correct_q   <= 2'd0;
            winner_q    <= 2'b00;
            secs_q      <= 4'd0;
            rev_q       <= 4'd0;
            time_up_q   <= 1'b0;
            game_over_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            lfsr_q      <= lfsr_d;
            cnt_q       <= cnt_d;
            hidden_q    <= hidden_d;
            c1_q        <= c1_d;
            c2_q        <= c2_d;
            p1_lives_q  <= p1_lives_d;
            p2_lives_q  <= p2_lives_d;
            correct_q   <= correct_d;
            winner_q    <= winner_d;
            secs_q      <= secs_d;
            rev_q       <= rev_d;
            time_up_q   <= time_up_d;
            game_over_q <= game_over_d;
        end
    end
endmodule

// File: tb/tb_game_controller.sv
// tb_game_controller: randomized scenario bench for game_controller against a round-level model
module tb_game_controller;
    logic       clk = 1'b0;
    logic       reset, start, p1_valid, p2_valid;
    logic [1:0] p1_door, p2_door;
    logic [1:0] p1_lives, p2_lives, correct_door, winner;
    logic       time_up, game_over;
    logic [3:0] secs_left;
    int         checks = 0, errors = 0;
    int         exp1, exp2;
    logic [1:0] exp_door;
    logic [7:0] m_lfsr;

    game_controller #(.TICKS_PER_SEC(4), .ROUND_SECS(3), .REVEAL_SECS(2), .START_LIVES(3)) dut (
        .clk(clk), .reset(reset), .start(start),
        .p1_valid(p1_valid), .p1_door(p1_door), .p2_valid(p2_valid), .p2_door(p2_door),
        .p1_lives(p1_lives), .p2_lives(p2_lives), .correct_door(correct_door), .time_up(time_up),
        .secs_left(secs_left), .game_over(game_over), .winner(winner)
    );

    always #5 clk = ~clk;

    // Random-door source: parity of the tapped bits shifted in each clock
    always @(posedge clk) m_lfsr <= reset ? 8'h01 : {m_lfsr[6:0], ^(m_lfsr & 8'hB8)};

    function automatic logic [1:0] hid();
        return (m_lfsr[1:0] == 2'd0) ? 2'd1 : m_lfsr[1:0];
    endfunction

    function automatic logic [1:0] other(input logic [1:0] d);
        int r;
        r = int'($urandom_range(0, 1));
        return 2'((int'(d) + r) % 3 + 1);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; start = 1'b0; p1_valid = 1'b0; p2_valid = 1'b0; p1_door = 2'd0; p2_door = 2'd0;
        step();
        step();
        reset = 1'b0;
        exp1 = 3;
        exp2 = 3;
    endtask

    task automatic begin_game();
        exp_door = hid();
        start = 1'b1;
        step();
        start = 1'b0;
        exp1 = 3;
        exp2 = 3;
    endtask

    // m: 0 silent, 1 correct, 2 wrong; t: cycle after round entry at which the strobe is driven
    task automatic run_round(input int m1, input int m2, input int t1, input int t2,
                             input bit extra, input bit noise, output bit over);
        int ex;
        bit c1, c2;
        logic [1:0] d1, d2, prev, ew;
        d1 = (m1 == 1) ? exp_door : other(exp_door);
        d2 = (m2 == 1) ? exp_door : other(exp_door);
        c1 = m1 != 0 && t1 <= 10;
        c2 = m2 != 0 && t2 <= 10;
        ex = (c1 && c2) ? ((t1 > t2 ? t1 : t2) + 2) : 12;
        for (int s = 0; s < ex; s++) begin
            checks++;
            if (secs_left !== 4'(3 - s / 4) || time_up !== 1'b0 || correct_door !== 2'd0 || game_over !== 1'b0) begin
                errors++;
                $display("FAIL round_s%0d secs=%0d time_up=%b door=%0d go=%b want secs=%0d 0 0 0",
                         s, secs_left, time_up, correct_door, game_over, 3 - s / 4);
            end
            p1_valid = (m1 != 0 && s == t1) || (extra && s == t1 + 1) || (noise && s == 5);
            p1_door  = (noise && s == 5) ? 2'd0 : (extra && s == t1 + 1) ? other(exp_door) : d1;
            start    = noise && s == 5;
            p2_valid = m2 != 0 && s == t2;
            p2_door  = d2;
            step();
        end
        p1_valid = 1'b0; p2_valid = 1'b0; start = 1'b0;
        if (!(c1 && m1 == 1) && exp1 > 0) exp1--;
        if (!(c2 && m2 == 1) && exp2 > 0) exp2--;
        checks++;
        if (time_up !== 1'b1 || correct_door !== exp_door || p1_lives !== 2'(exp1) || p2_lives !== 2'(exp2) || game_over !== 1'b0) begin
            errors++;
            $display("FAIL reveal_entry time_up=%b door=%0d lives=%0d/%0d go=%b want 1 %0d %0d/%0d 0",
                     time_up, correct_door, p1_lives, p2_lives, game_over, exp_door, exp1, exp2);
        end
        for (int s = 1; s < 8; s++) begin
            step();
            checks++;
            if (time_up !== 1'b1 || correct_door !== exp_door || p1_lives !== 2'(exp1) || p2_lives !== 2'(exp2)) begin
                errors++;
                $display("FAIL reveal_hold_s%0d time_up=%b door=%0d lives=%0d/%0d want 1 %0d %0d/%0d",
                         s, time_up, correct_door, p1_lives, p2_lives, exp_door, exp1, exp2);
            end
        end
        prev = exp_door;
        exp_door = hid();
        step();
        over = exp1 == 0 || exp2 == 0;
        ew = {exp1 == 0, exp2 == 0};
        checks++;
        if (over) begin
            if (game_over !== 1'b1 || winner !== ew || time_up !== 1'b1 || correct_door !== prev) begin
                errors++;
                $display("FAIL game_over_entry go=%b winner=%b time_up=%b door=%0d want 1 %b 1 %0d",
                         game_over, winner, time_up, correct_door, ew, prev);
            end
        end else if (secs_left !== 4'd3 || correct_door !== 2'd0 || time_up !== 1'b0 || winner !== 2'b00) begin
            errors++;
            $display("FAIL next_round secs=%0d door=%0d time_up=%b winner=%b want 3 0 0 00",
                     secs_left, correct_door, time_up, winner);
        end
    endtask

    task automatic check_idle(input string name);
        checks++;
        if (p1_lives !== 2'd3 || p2_lives !== 2'd3 || correct_door !== 2'd0 || time_up !== 1'b0 ||
            secs_left !== 4'd0 || winner !== 2'b00 || game_over !== 1'b0) begin
            errors++;
            $display("FAIL %s lives=%0d/%0d door=%0d time_up=%b secs=%0d winner=%b go=%b want 3/3 0 0 0 00 0",
                     name, p1_lives, p2_lives, correct_door, time_up, secs_left, winner, game_over);
        end
    endtask

    task automatic test_reset();
        do_reset();
        check_idle("reset_values");
        repeat (20) step();
        check_idle("idle_20");
        begin_game();
        repeat (5) step();
        reset = 1'b1;
        step();
        check_idle("reset_mid_round");
        start = 1'b1;
        step();
        check_idle("reset_beats_start");
        reset = 1'b0;
        start = 1'b0;
        step();
        check_idle("idle_after_reset");
    endtask

    task automatic test_timeout();
        bit over;
        do_reset();
        repeat ($urandom_range(0, 7)) step();
        begin_game();
        run_round(0, 0, 0, 0, 1'b0, 1'b0, over);
    endtask

    task automatic test_same_cycle();
        bit over;
        do_reset();
        begin_game();
        run_round(1, 2, 0, 0, 1'b1, 1'b0, over);
        checks++;
        if (p1_lives !== 2'd3 || p2_lives !== 2'd2) begin
            errors++;
            $display("FAIL same_cycle_lives got %0d/%0d want 3/2", p1_lives, p2_lives);
        end
    endtask

    task automatic test_p2_loses();
        bit over;
        do_reset();
        begin_game();
        for (int r = 0; r < 3; r++)
            run_round(1, 2, int'($urandom_range(0, 9)), int'($urandom_range(0, 9)), 1'b0, 1'b0, over);
        checks++;
        if (over !== 1'b1 || winner !== 2'b01) begin
            errors++;
            $display("FAIL p2_loses over=%b winner=%b want 1 01", over, winner);
        end
        repeat (10) step();
        checks++;
        if (game_over !== 1'b1 || time_up !== 1'b1 || winner !== 2'b01) begin
            errors++;
            $display("FAIL game_over_hold go=%b time_up=%b winner=%b want 1 1 01", game_over, time_up, winner);
        end
        begin_game();
        checks++;
        if (p1_lives !== 2'd3 || p2_lives !== 2'd3 || winner !== 2'b00 || secs_left !== 4'd3 ||
            game_over !== 1'b0 || time_up !== 1'b0 || correct_door !== 2'd0) begin
            errors++;
            $display("FAIL restart lives=%0d/%0d winner=%b secs=%0d go=%b time_up=%b door=%0d want 3/3 00 3 0 0 0",
                     p1_lives, p2_lives, winner, secs_left, game_over, time_up, correct_door);
        end
        run_round(2, 1, int'($urandom_range(0, 9)), int'($urandom_range(0, 9)), 1'b0, 1'b0, over);
    endtask

    task automatic test_both_silent();
        bit over;
        do_reset();
        begin_game();
        run_round(0, 0, 0, 0, 1'b0, 1'b0, over);
        run_round(0, 0, 0, 0, 1'b0, 1'b0, over);
        run_round(1, 0, 11, 0, 1'b0, 1'b0, over);
        checks++;
        if (winner !== 2'b11 || p1_lives !== 2'd0 || p2_lives !== 2'd0) begin
            errors++;
            $display("FAIL both_silent winner=%b lives=%0d/%0d want 11 0/0", winner, p1_lives, p2_lives);
        end
    endtask

    task automatic test_noise();
        bit over;
        do_reset();
        begin_game();
        run_round(0, 1, 0, int'($urandom_range(0, 11)), 1'b0, 1'b1, over);
        run_round(0, 0, 0, 0, 1'b0, 1'b1, over);
    endtask

    task automatic test_random();
        bit over;
        for (int g = 0; g < 3; g++) begin
            do_reset();
            repeat ($urandom_range(0, 9)) step();
            begin_game();
            over = 1'b0;
            for (int r = 0; r < 6 && !over; r++)
                run_round(int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                          int'($urandom_range(0, 11)), int'($urandom_range(0, 11)), 1'b0, 1'b0, over);
        end
    endtask

    initial begin
        test_reset();
        test_timeout();
        test_same_cycle();
        test_p2_loses();
        test_both_silent();
        test_noise();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
